qtcore_scan_loader: RTL and testbench
=====================================

// Module: qtcore_scan_loader
// PURPOSE
//  Hardware host for the qtcore A1 scan chain; sits directly upstream of lucaz97_tt_top, driving
//  its scan pins. Accepts a full chain image as a byte stream and shifts it serially into the core,
//  capturing what the core shifts out. It then returns the captured image as a byte stream.
//  The chain image carries the 16-bit unlock key in its top 16 bits, passed through untouched.
// PARAMETERS
//  SCAN_CHAIN_SIZE  160  chain length in bits (24 + 15*8 + 16); must be a multiple of 8
//  MAX_RUN_CYCLES   256  run-phase cycle limit (used only with QTCORE_SCAN_RUN_EN)
// PORTS
//  clk_in            in   1   clock, shared with the core (rising edge)
//  rst_n_in          in   1   asynchronous, active-low reset
//  start_in          in   1   1-cycle pulse: begin a transaction (ignored while busy_out=1)
//  byte_in           in   8   image byte, MSB byte of chain first
//  byte_valid_in     in   1   byte_in valid
//  byte_ready_out    out  1   loader accepts byte_in (LOAD state only)
//  byte_out          out  8   captured byte, MSB byte of chain first
//  byte_valid_out    out  1   byte_out valid
//  byte_ready_in     in   1   consumer accepts byte_out
//  scan_enable_out   out  1   to core scan enable (active-high here; top level inverts for io_in[2])
//  scan_data_out     out  1   to core scan_in
//  scan_data_in      in   1   from core scan_out (also the halt flag when not scanning)
//  proc_en_out       out  1   to core processor enable (run phase)
//  busy_out          out  1   high from start acceptance until done_out
//  done_out          out  1   1-cycle pulse after the last byte_out handshake
//  run_cycles_out    out  9   run-phase cycle count, held until next start
//  timeout_out       out  1   run phase ended on MAX_RUN_CYCLES without halt
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, shift buffer and counters cleared. Reset mid-operation
//    aborts immediately; scan_enable_out and proc_en_out drop asynchronously.
//  - State machine: IDLE -> LOAD -> SHIFT -> GAP -> [RUN -> SHIFT2 -> GAP2 ->] UNLOAD -> IDLE.
//  - IDLE: start_in=1 -> LOAD. byte_valid_in is ignored in IDLE.
//  - LOAD: byte_ready_out=1. Each handshake does buf <= {buf[N-9:0], byte_in}. After N/8 bytes -> SHIFT.
//  - SHIFT: scan_enable_out=1 for exactly N rising edges. scan_data_out=buf[N-1].
//    On each edge: buf <= {buf[N-2:0], scan_data_in}. scan_data_in is sampled at the same edge the core shifts.
//  - GAP: one cycle with scan_enable_out=0 and proc_en_out=0. Lets the core settle.
//  - UNLOAD: byte_out=buf[N-1:N-8], byte_valid_out=1. Value is held stable until byte_ready_in=1.
//    Each handshake does buf <<= 8. After N/8 handshakes, done_out pulses and state -> IDLE.
//  - start_in while busy: ignored. byte_ready_out=0 outside LOAD; byte_valid_out=0 outside UNLOAD.
//  - Latency without stalls: N/8 load cycles + N shift cycles + 1 gap cycle + N/8 unload cycles.
// CONFIGURATION
//  QTCORE_SCAN_RUN_EN defined:
//    - After GAP, enter RUN: proc_en_out=1. run count increments each cycle.
//    - Leave RUN when (count>=4 && scan_data_in==1) [halt], or when count==MAX_RUN_CYCLES [timeout_out=1].
//    - run_cycles_out = final count.
//    - SHIFT2: N edges with scan_data_out=0 (zeros shifted into the core), capturing as in SHIFT.
//    - GAP2: one idle cycle. UNLOAD then returns the post-run core state.
//  Not defined:
//    - GAP -> UNLOAD directly; UNLOAD returns the pre-transaction core state.
//    - proc_en_out, run_cycles_out and timeout_out are tied 0.
// TESTING
//  (bench core model: 160-bit shift register, shifts on scan_enable, scan_out=MSB)
//  1 reset: pulse rst_n_in low -> all outputs 0; byte_ready_out=0 even with byte_valid_in=1.
//  2 exchange: model preloaded 0xA5 x20; load bytes 0x00..0x13 -> model holds 0x00 in bits
//    [159:152] ... 0x13 in [7:0]; scan_enable_out high exactly 160 cycles; unload returns 20 x 0xA5.
//  3 backpressure: byte_ready_in low 5 cycles on unload byte 3 -> byte_out stable, no byte lost or duplicated.
//  4 reset at shift cycle 80 -> scan_enable_out=0 immediately, busy_out=0. A new start then
//    completes a full exchange normally.
//  5 (RUN_EN) model raises halt after 10 run cycles -> run_cycles_out=10, timeout_out=0,
//    unload returns the model's post-run contents. Halt never raised -> run_cycles_out=256, timeout_out=1.
//  6 start_in pulsed during SHIFT and UNLOAD -> ignored; exactly one done_out pulse per transaction.

Source files
------------

// File: rtl/qtcore_scan_loader.sv
// Scan-chain host for the qtcore A1: loads a chain image from a byte stream, shifts it through
// the core while capturing the old contents, then streams the capture back. Option: QTCORE_SCAN_RUN_EN.
module qtcore_scan_loader #(
   parameter int SCAN_CHAIN_SIZE = 160,
   parameter int MAX_RUN_CYCLES  = 256
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       start_in,
   input  logic [7:0] byte_in,
   input  logic       byte_valid_in,
   output logic       byte_ready_out,
   output logic [7:0] byte_out,
   output logic       byte_valid_out,
   input  logic       byte_ready_in,
   output logic       scan_enable_out,
   output logic       scan_data_out,
   input  logic       scan_data_in,
   output logic       proc_en_out,
   output logic       busy_out,
   output logic       done_out,
   output logic [8:0] run_cycles_out,
   output logic       timeout_out
);

   localparam int N      = SCAN_CHAIN_SIZE;
   localparam int NBYTES = N / 8;
   localparam int BYTE_W = $clog2(NBYTES + 1);
   localparam int BIT_W  = $clog2(N + 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(N - 1);
   localparam logic [8:0]        RUN_LIMIT = 9'(MAX_RUN_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_RUN, S_SHIFT2, S_GAP2, S_UNLOAD
   } state_t;

   state_t            state_reg, state_next;
   logic [N-1:0]      shift_reg, shift_next;
   logic [BYTE_W-1:0] byte_cnt_reg, byte_cnt_next;
   logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [8:0]        run_cnt_reg, run_cnt_next;
   logic              timeout_reg, timeout_next;
   logic              done_reg, done_next;
   logic [8:0]        run_inc;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg    <= S_IDLE;
         shift_reg    <= '0;
         byte_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         run_cnt_reg  <= '0;
         timeout_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         byte_cnt_reg <= byte_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         run_cnt_reg  <= run_cnt_next;
         timeout_reg  <= timeout_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      byte_cnt_next   = byte_cnt_reg;
      bit_cnt_next    = bit_cnt_reg;
      run_cnt_next    = run_cnt_reg;
      timeout_next    = timeout_reg;
      done_next       = 1'b0;
      byte_ready_out  = 1'b0;
      byte_valid_out  = 1'b0;
      byte_out        = 8'h00;
      scan_enable_out = 1'b0;
      scan_data_out   = 1'b0;
      proc_en_out     = 1'b0;
      run_inc         = run_cnt_reg + 9'd1;

      case (state_reg)
         S_IDLE: begin
            if (start_in) begin
               state_next    = S_LOAD;
               byte_cnt_next = '0;
               run_cnt_next  = '0;
               timeout_next  = 1'b0;
            end
         end
         S_LOAD: begin
            byte_ready_out = 1'b1;
            if (byte_valid_in) begin
               shift_next = {shift_reg[N-9:0], byte_in};
               if (byte_cnt_reg == LAST_BYTE) begin
                  byte_cnt_next = '0;
                  state_next    = S_SHIFT;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 1'b1;
               end
            end
         end
         // Both scan passes capture the core's outgoing MSB; only the first drives the image in.
         S_SHIFT, S_SHIFT2: begin
            scan_enable_out = 1'b1;
            scan_data_out   = (state_reg == S_SHIFT) ? shift_reg[N-1] : 1'b0;
            shift_next      = {shift_reg[N-2:0], scan_data_in};
            if (bit_cnt_reg == LAST_BIT) begin
               bit_cnt_next = '0;
               state_next   = (state_reg == S_SHIFT) ? S_GAP : S_GAP2;
            end else begin
               bit_cnt_next = bit_cnt_reg + 1'b1;
            end
         end
         S_GAP: begin
`ifdef QTCORE_SCAN_RUN_EN
            state_next = S_RUN;
`else
            state_next = S_UNLOAD;
`endif
         end
         // Outside scanning, scan_data_in is the core's halt flag; halts in the first 3 cycles are ignored.
         S_RUN: begin
            proc_en_out  = 1'b1;
            run_cnt_next = run_inc;
            if (run_inc >= 9'd4 && scan_data_in) begin
               state_next = S_SHIFT2;
            end else if (run_inc == RUN_LIMIT) begin
               timeout_next = 1'b1;
               state_next   = S_SHIFT2;
            end
         end
         S_GAP2: begin
            state_next = S_UNLOAD;
         end
         S_UNLOAD: begin
            byte_valid_out = 1'b1;
            byte_out       = shift_reg[N-1 -: 8];
            if (byte_ready_in) begin
               shift_next = {shift_reg[N-9:0], 8'h00};
               if (byte_cnt_reg == LAST_BYTE) begin
                  byte_cnt_next = '0;
                  done_next     = 1'b1;
                  state_next    = S_IDLE;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign busy_out       = (state_reg != S_IDLE);
   assign done_out       = done_reg;
   assign run_cycles_out = run_cnt_reg;
   assign timeout_out    = timeout_reg;

endmodule

// File: tb/tb_qtcore_scan_loader.sv
// Bench for qtcore_scan_loader: a 160-bit shift-register core model plus an image-level model of
// what each transaction must return. Honors QTCORE_SCAN_RUN_EN when defined.
module tb_qtcore_scan_loader;

   localparam int N  = 160;
   localparam int NB = N / 8;

   logic       clk = 1'b0;
   logic       rst_n_in, start_in, byte_valid_in, byte_ready_in;
   logic [7:0] byte_in;
   logic       byte_ready_out, byte_valid_out;
   logic [7:0] byte_out;
   logic       scan_enable_out, scan_data_out, scan_data_in, proc_en_out;
   logic       busy_out, done_out, timeout_out;
   logic [8:0] run_cycles_out;

   always #5 clk = ~clk;

   qtcore_scan_loader dut (
      .clk_in(clk), .rst_n_in(rst_n_in), .start_in(start_in),
      .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
      .byte_out(byte_out), .byte_valid_out(byte_valid_out), .byte_ready_in(byte_ready_in),
      .scan_enable_out(scan_enable_out), .scan_data_out(scan_data_out), .scan_data_in(scan_data_in),
      .proc_en_out(proc_en_out), .busy_out(busy_out), .done_out(done_out),
      .run_cycles_out(run_cycles_out), .timeout_out(timeout_out)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Core model: shifts on scan enable, increments its whole state once per enabled processor
   // cycle, and raises halt from its halt_at-th processor cycle onwards.
   logic [N-1:0] core_reg = '0;
   logic [N-1:0] core_load_val = '0;
   logic         core_load = 1'b0;
   int           proc_edges = 0;
   int           halt_at = 1000;

   always @(posedge clk) begin
      if (core_load) begin
         core_reg   <= core_load_val;
         proc_edges <= 0;
      end else if (scan_enable_out) begin
         core_reg <= {core_reg[N-2:0], scan_data_out};
      end else if (proc_en_out) begin
         core_reg   <= core_reg + 1'b1;
         proc_edges <= proc_edges + 1;
      end
   end

   assign scan_data_in = scan_enable_out ? core_reg[N-1] : (proc_edges >= halt_at - 1);

   // Compare process: unload bytes against the expected queue, hold-under-stall, event counts.
   logic [7:0] exp_q[$];
   logic [7:0] got_log[$];
   int         sen_cnt = 0;
   int         done_cnt = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] stall_byte = 8'h00;

   always @(negedge clk) begin
      if (!rst_n_in) begin
         stall_prev <= 1'b0;
      end else begin
         if (byte_valid_out && byte_ready_in) begin
            got_log.push_back(byte_out);
            if (exp_q.size() == 0) chk("unload_extra_byte", {152'd0, byte_out}, '1);
            else chk("unload_byte", {152'd0, byte_out}, {152'd0, exp_q.pop_front()});
         end
         if (stall_prev) chk("unload_hold", {151'd0, byte_valid_out, byte_out}, {151'd0, 1'b1, stall_byte});
         if (byte_ready_out || byte_valid_out) chk("ready_valid_exclusive", {159'd0, byte_ready_out & byte_valid_out}, '0);
         stall_prev <= byte_valid_out && !byte_ready_in;
         stall_byte <= byte_out;
         if (scan_enable_out) sen_cnt <= sen_cnt + 1;
         if (done_out) done_cnt <= done_cnt + 1;
      end
   end

   // Image-level reference of one transaction.
   task automatic model(input logic [N-1:0] img, input logic [N-1:0] pre, input int halt,
                        output logic [N-1:0] out_img, output logic [N-1:0] core_after,
                        output int n, output int to, output int lat);
`ifdef QTCORE_SCAN_RUN_EN
      n  = (halt < 4) ? 4 : halt;
      to = 0;
      if (n > 256) begin
         n  = 256;
         to = 1;
      end
      out_img    = img + N'(n);
      core_after = '0;
      lat        = NB + N + 1 + n + N + 1 + NB;
`else
      n          = 0;
      to         = 0;
      out_img    = pre;
      core_after = img;
      lat        = NB + N + 1 + NB;
`endif
   endtask

   int txn_no = 0;

   task automatic do_txn(input logic [N-1:0] img, input logic [N-1:0] pre, input int halt,
                         input int st_idx, input int st_len, input bit poke, input int abort_at);
      logic [N-1:0] exp_img, exp_core;
      int exp_n, exp_to, exp_lat, edges, load_i, out_i, stall_cnt, sen0, done0;
      bit hs_in, hs_out, v_out, done_seen;
      core_load_val = pre;
      core_load     = 1'b1;
      @(posedge clk); #1;
      core_load = 1'b0;
      halt_at   = halt;
      model(img, pre, halt, exp_img, exp_core, exp_n, exp_to, exp_lat);
      if (st_len > 0 && st_idx < NB) exp_lat += st_len;
      exp_q.delete();
      for (int i = 0; i < NB; i++) exp_q.push_back(exp_img[N-1-8*i -: 8]);
      sen0 = sen_cnt;
      done0 = done_cnt;
      load_i = 0; out_i = 0; stall_cnt = 0; edges = 0; done_seen = 0;
      byte_in = img[N-1 -: 8];
      byte_valid_in = 1'b1;
      byte_ready_in = 1'b1;
      start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      chk("busy_after_start", {159'd0, busy_out}, 1);
      while (!done_seen && edges < exp_lat + 50) begin
         byte_ready_in = !(out_i == st_idx && stall_cnt < st_len);
         @(negedge clk);
         hs_in  = byte_valid_in && byte_ready_out;
         hs_out = byte_valid_out && byte_ready_in;
         v_out  = byte_valid_out;
         @(posedge clk); #1;
         edges++;
         if (hs_in) begin
            load_i++;
            if (load_i < NB) byte_in = img[N-1-8*load_i -: 8];
            else begin
               byte_valid_in = 1'b0;
               byte_in = 8'h00;
            end
         end
         if (hs_out) out_i++;
         else if (v_out && !byte_ready_in) stall_cnt++;
         start_in = poke && (edges == 100 || edges == exp_lat - 3);
         if (abort_at > 0 && edges == abort_at) begin
            chk("shift_before_reset", {159'd0, scan_enable_out}, 1);
            #2 rst_n_in = 1'b0;
            #1;
            chk("reset_scan_enable", {159'd0, scan_enable_out}, 0);
            chk("reset_busy", {159'd0, busy_out}, 0);
            chk("reset_proc_en", {159'd0, proc_en_out}, 0);
            @(posedge clk); #1;
            rst_n_in = 1'b1;
            start_in = 1'b0;
            byte_valid_in = 1'b0;
            exp_q.delete();
            $display("txn %0d: aborted by reset after %0d edges", txn_no, edges);
            txn_no++;
            return;
         end
         done_seen = done_out;
      end
      start_in = 1'b0;
      chk("done_seen", {159'd0, done_seen}, 1);
      chk("latency", N'(edges), N'(exp_lat));
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", N'(done_cnt - done0), 1);
`ifdef QTCORE_SCAN_RUN_EN
      chk("scan_cycles", N'(sen_cnt - sen0), N'(2 * N));
`else
      chk("scan_cycles", N'(sen_cnt - sen0), N'(N));
`endif
      chk("idle_busy", {159'd0, busy_out}, 0);
      chk("unload_count", N'(exp_q.size()), 0);
      chk("run_cycles", {151'd0, run_cycles_out}, N'(exp_n));
      chk("timeout", {159'd0, timeout_out}, N'(exp_to));
      chk("core_contents", core_reg, exp_core);
      $display("txn %0d: latency=%0d run=%0d timeout=%0d stall=%0d@%0d", txn_no, edges,
               run_cycles_out, timeout_out, st_len, st_idx);
      txn_no++;
   endtask

   function automatic logic [N-1:0] rand_img();
      logic [N-1:0] v;
      for (int i = 0; i < N / 32; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   logic [N-1:0] ramp_img, a5_img;

   initial begin
      rst_n_in = 1'b0;
      start_in = 1'b0;
      byte_in = 8'h00;
      byte_valid_in = 1'b1;
      byte_ready_in = 1'b1;
      for (int i = 0; i < NB; i++) begin
         ramp_img[N-1-8*i -: 8] = 8'(i);
         a5_img[N-1-8*i -: 8]   = 8'hA5;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {143'd0, byte_ready_out, byte_valid_out, byte_out, scan_enable_out,
                          scan_data_out, proc_en_out, busy_out, done_out, timeout_out}, '0);
      chk("rst_run_cycles", {151'd0, run_cycles_out}, '0);
      rst_n_in = 1'b1;
      @(posedge clk); #1;
      chk("idle_ignores_valid", {158'd0, byte_ready_out, busy_out}, '0);
      byte_valid_in = 1'b0;

      // Ramp image into a core preloaded with 0xA5.
`ifdef QTCORE_SCAN_RUN_EN
      do_txn(ramp_img, a5_img, 10, 99, 0, 1'b0, 0);
      chk("pin_run_cycles_10", {151'd0, run_cycles_out}, 10);
      chk("pin_first_byte", {152'd0, got_log[0]}, 8'h00);
      chk("pin_last_byte", {152'd0, got_log[NB-1]}, 8'h1D);
      do_txn(ramp_img, a5_img, 1000, 99, 0, 1'b0, 0);
      chk("pin_timeout_cycles", {151'd0, run_cycles_out}, 256);
      chk("pin_timeout_flag", {159'd0, timeout_out}, 1);
      chk("pin_timeout_byte18", {152'd0, got_log[got_log.size()-2]}, 8'h13);
`else
      do_txn(ramp_img, a5_img, 1000, 99, 0, 1'b0, 0);
      chk("pin_unload_first", {152'd0, got_log[0]}, 8'hA5);
      chk("pin_unload_last", {152'd0, got_log[NB-1]}, 8'hA5);
      chk("pin_core_top", {152'd0, core_reg[159:152]}, 8'h00);
      chk("pin_core_mid", {152'd0, core_reg[87:80]}, 8'h09);
      chk("pin_core_low", {152'd0, core_reg[7:0]}, 8'h13);
`endif
      // Backpressure on unload byte 3.
      do_txn(rand_img(), rand_img(), 12, 3, 5, 1'b0, 0);
      // Reset in the middle of the shift, then a clean exchange.
      do_txn(rand_img(), rand_img(), 12, 99, 0, 1'b0, NB + 80);
      do_txn(rand_img(), rand_img(), 7, 99, 0, 1'b0, 0);
      // Stray starts while busy.
      do_txn(rand_img(), rand_img(), 2, 99, 0, 1'b1, 0);
      for (int t = 0; t < 5; t++) begin
         do_txn(rand_img(), rand_img(), int'($urandom_range(1, 40)), int'($urandom_range(0, NB - 1)),
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
